uart_register_block: RTL and testbench
======================================

# uart_register_block

Register file between the APB-facing `apb_interface` and the UART TX/RX cores. It decodes single-cycle byte writes and reads from `apb_interface` and holds the TX data, RX data, configuration, control and status registers. It sequences `start_tx` launches against the transmitter's `tx_done` handshake and returns RX data and status flags to `apb_interface`.

## Interface

Parameters:
- ADDR_W, 5, register address width (byte address, registers on 4-byte boundaries)

Ports:
- pclk  in  1  clock, all state on rising edge
- presetn  in  1  asynchronous active-low reset
- reg_wr_en  in  1  one-cycle write strobe from apb_interface
- reg_rd_en  in  1  one-cycle read strobe from apb_interface
- reg_address_des  in  ADDR_W  register address
- data_write_to_reg  in  8  write data
- reg_rd_data  out  8  registered read data
- reg_rd_valid  out  1  one-cycle pulse, reg_rd_data valid
- reg_err  out  1  one-cycle pulse, illegal access
- rx_data_in  out  8  rx_data_reg contents, to apb_interface
- tx_done_signal  out  1  stt_reg[0]
- rx_done_signal  out  1  stt_reg[1]
- parity_error_signal  out  1  stt_reg[2]
- tx_data  out  8  byte to transmit
- start_tx  out  1  one-cycle launch pulse to TX core
- data_bit_num  out  2  cfg[1:0]: 00=5, 01=6, 10=7, 11=8 data bits
- stop_bit_num  out  1  cfg[2]: 0=1 stop bit, 1=2 stop bits
- parity_en  out  1  cfg[3]
- parity_type  out  1  cfg[4]: 0=even, 1=odd
- tx_done  in  1  TX core level, 1 = idle or finished
- rx_done  in  1  RX core one-cycle pulse, byte received
- rx_data  in  8  RX byte, valid with rx_done
- parity_error  in  1  RX core one-cycle pulse, parity mismatch

## Operation

- Register map:
  - 0x00 tx_data_reg: RW.
  - 0x04 rx_data_reg: RO.
  - 0x08 cfg_reg: RW, bits [4:0]. Bits [7:5] read 0 and ignore writes.
  - 0x0C ctrl_reg: RW, bit [0] = start_tx request. Bits [7:1] read 0.
  - 0x10 stt_reg: RO. Bit 0 = live tx_done, bit 1 = sticky rx_done, bit 2 = sticky parity_error.
- Reset values:
  - tx_data_reg = 0x00, rx_data_reg = 0x00, cfg_reg = 0x03, ctrl_reg = 0x00, sticky bits = 0.
  - All outputs 0, except data_bit_num = 2'b11.
  - TX FSM in IDLE.
- TX FSM:
  - IDLE: on a write to ctrl with bit0 = 1, set ctrl[0] and go to PEND.
  - PEND: when tx_done = 1, go to LAUNCH.
  - LAUNCH: start_tx = 1 for exactly this cycle; clear ctrl[0]; go to WAIT.
  - WAIT: when tx_done = 0, go to IDLE.
- Busy = FSM not in IDLE. While busy, these are dropped, leave registers unchanged and pulse reg_err:
  - writes to tx_data_reg or cfg_reg;
  - ctrl writes with bit0 = 1.
- A ctrl write with bit0 = 0 in IDLE is accepted and has no effect.
- RX capture:
  - rx_done pulse: rx_data_reg <= rx_data, stt[1] <= 1.
  - parity_error pulse: stt[2] <= 1. The byte is still captured if rx_done is also high.
- Clear-on-read: a read of 0x10 clears stt[1] and stt[2] after returning their pre-clear value. If a set event occurs in the same cycle as the clear, set wins.
- Illegal accesses, each pulsing reg_err:
  - write to 0x04 or 0x10, or to any unmapped address: no state change;
  - read of an unmapped address: reg_rd_data = 0x00.
- reg_wr_en and reg_rd_en high in the same cycle: the write is performed, the read is ignored, reg_err pulses.

## Timing

- Write: registers update on the edge sampling reg_wr_en. The new value is visible on outputs the next cycle.
- Read: reg_rd_data and reg_rd_valid are registered, 1-cycle latency. reg_rd_data holds its value until the next read.
- reg_err: asserted the cycle after the offending strobe.
- start_tx latency: ctrl write edge, then PEND at edge +1, then start_tx high in cycle +2 at the earliest (tx_done already 1). If tx_done = 0, the FSM stays in PEND indefinitely.
- tx_data and cfg outputs are stable from before start_tx until the FSM returns to IDLE.
- stt[1] and stt[2] are set the cycle after the RX pulse. stt[0] follows tx_done with 1 cycle of register delay.
- Reset asserted mid-transfer: everything returns to reset values asynchronously; a pending start_tx is lost.

## Test plan

- Reset: deassert presetn → cfg reads 0x03, data_bit_num = 11, all other reads 0x00, start_tx = 0.
- Launch: write 0x00 = 0xA5, then 0x0C = 0x01 with tx_done = 1 → one start_tx pulse 2 cycles after the ctrl write, tx_data = 0xA5, ctrl reads 0x00 afterwards.
- Pending launch: hold tx_done = 0 and write ctrl = 0x01 → no start_tx; while pending, write 0x00 = 0x3C → reg_err, tx_data stays 0xA5. Raise tx_done → start_tx one cycle after PEND sees it.
- RX with error: rx_data = 0x5A with simultaneous rx_done and parity_error → rx_data_in = 0x5A, stt reads 0x07 with tx_done = 1. A second stt read returns 0x01.
- Clear/set collision: read 0x10 in the same cycle as an rx_done pulse → stt[1] remains 1.
- Illegal access: write 0x10, read 0x14, simultaneous wr+rd → reg_err each time, no register change, read data 0x00.

Source files
------------

// File: rtl/uart_register_block.sv
// UART register file: decodes byte-wide register accesses, holds TX/RX/config/control/status
// registers and sequences start_tx launches against the transmitter's tx_done handshake.
module uart_register_block #(
    parameter int ADDR_W = 5
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              reg_wr_en,
    input  logic              reg_rd_en,
    input  logic [ADDR_W-1:0] reg_address_des,
    input  logic [7:0]        data_write_to_reg,
    output logic [7:0]        reg_rd_data,
    output logic              reg_rd_valid,
    output logic              reg_err,
    output logic [7:0]        rx_data_in,
    output logic              tx_done_signal,
    output logic              rx_done_signal,
    output logic              parity_error_signal,
    output logic [7:0]        tx_data,
    output logic              start_tx,
    output logic [1:0]        data_bit_num,
    output logic              stop_bit_num,
    output logic              parity_en,
    output logic              parity_type,
    input  logic              tx_done,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              parity_error
);

    localparam logic [ADDR_W-1:0] ADDR_TX   = ADDR_W'(5'h00);
    localparam logic [ADDR_W-1:0] ADDR_RX   = ADDR_W'(5'h04);
    localparam logic [ADDR_W-1:0] ADDR_CFG  = ADDR_W'(5'h08);
    localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(5'h0C);
    localparam logic [ADDR_W-1:0] ADDR_STT  = ADDR_W'(5'h10);

    typedef enum logic [1:0] {IDLE, PEND, LAUNCH, WAIT} tx_state_t;

    tx_state_t   state;
    logic [7:0]  tx_data_reg;
    logic [7:0]  rx_data_reg;
    logic [4:0]  cfg_reg;
    logic        ctrl_start;
    logic        rx_sticky;
    logic        par_sticky;
    logic        tx_done_q;

    logic        busy;
    logic        hit_tx, hit_rx, hit_cfg, hit_ctrl, hit_stt, hit_any;
    logic        wr_tx, wr_cfg, launch_req;
    logic        wr_err, rd_ok, rd_err, stt_clr;
    logic [7:0]  rd_mux;

    always_comb begin
        busy     = (state != IDLE);
        hit_tx   = (reg_address_des == ADDR_TX);
        hit_rx   = (reg_address_des == ADDR_RX);
        hit_cfg  = (reg_address_des == ADDR_CFG);
        hit_ctrl = (reg_address_des == ADDR_CTRL);
        hit_stt  = (reg_address_des == ADDR_STT);
        hit_any  = hit_tx | hit_rx | hit_cfg | hit_ctrl | hit_stt;

        // Registers feeding the TX core are frozen while a launch is in flight.
        wr_tx      = reg_wr_en && hit_tx && !busy;
        wr_cfg     = reg_wr_en && hit_cfg && !busy;
        launch_req = reg_wr_en && hit_ctrl && data_write_to_reg[0] && !busy;
        wr_err     = reg_wr_en && (((hit_tx || hit_cfg) && busy)
                                   || (hit_ctrl && data_write_to_reg[0] && busy)
                                   || !(hit_tx || hit_cfg || hit_ctrl));

        rd_ok   = reg_rd_en && !reg_wr_en;
        rd_err  = rd_ok && !hit_any;
        stt_clr = rd_ok && hit_stt;

        rd_mux = 8'h00;
        if (hit_tx)   rd_mux = tx_data_reg;
        if (hit_rx)   rd_mux = rx_data_reg;
        if (hit_cfg)  rd_mux = {3'b000, cfg_reg};
        if (hit_ctrl) rd_mux = {7'b0000000, ctrl_start};
        if (hit_stt)  rd_mux = {5'b00000, par_sticky, rx_sticky, tx_done_q};
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= IDLE;
            tx_data_reg  <= 8'h00;
            rx_data_reg  <= 8'h00;
            cfg_reg      <= 5'b00011;
            ctrl_start   <= 1'b0;
            rx_sticky    <= 1'b0;
            par_sticky   <= 1'b0;
            tx_done_q    <= 1'b0;
            start_tx     <= 1'b0;
            reg_rd_data  <= 8'h00;
            reg_rd_valid <= 1'b0;
            reg_err      <= 1'b0;
        end else begin
            if (wr_tx)  tx_data_reg <= data_write_to_reg;
            if (wr_cfg) cfg_reg     <= data_write_to_reg[4:0];
            if (rx_done) rx_data_reg <= rx_data;

            // A new event in the clearing cycle must not be lost, so set wins.
            rx_sticky  <= rx_done      || (rx_sticky  && !stt_clr);
            par_sticky <= parity_error || (par_sticky && !stt_clr);
            tx_done_q  <= tx_done;

            reg_err      <= wr_err || rd_err || (reg_wr_en && reg_rd_en);
            reg_rd_valid <= rd_ok;
            if (rd_ok) reg_rd_data <= rd_mux;

            start_tx <= 1'b0;
            case (state)
                IDLE: if (launch_req) begin
                    ctrl_start <= 1'b1;
                    state      <= PEND;
                end
                PEND: if (tx_done) begin
                    start_tx <= 1'b1;
                    state    <= LAUNCH;
                end
                LAUNCH: begin
                    ctrl_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: if (!tx_done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign rx_data_in          = rx_data_reg;
    assign tx_done_signal      = tx_done_q;
    assign rx_done_signal      = rx_sticky;
    assign parity_error_signal = par_sticky;
    assign tx_data             = tx_data_reg;
    assign data_bit_num        = cfg_reg[1:0];
    assign stop_bit_num        = cfg_reg[2];
    assign parity_en           = cfg_reg[3];
    assign parity_type         = cfg_reg[4];

endmodule

// File: tb/tb_uart_register_block.sv
// Bench for uart_register_block: directed literal checks plus randomized traffic compared every
// cycle against a register-map model of the block.
module tb_uart_register_block;

    logic       pclk = 1'b0;
    logic       presetn = 1'b0;
    logic       reg_wr_en = 1'b0;
    logic       reg_rd_en = 1'b0;
    logic [4:0] reg_address_des = 5'h00;
    logic [7:0] data_write_to_reg = 8'h00;
    logic [7:0] reg_rd_data;
    logic       reg_rd_valid;
    logic       reg_err;
    logic [7:0] rx_data_in;
    logic       tx_done_signal;
    logic       rx_done_signal;
    logic       parity_error_signal;
    logic [7:0] tx_data;
    logic       start_tx;
    logic [1:0] data_bit_num;
    logic       stop_bit_num;
    logic       parity_en;
    logic       parity_type;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       parity_error = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    uart_register_block #(.ADDR_W(5)) dut (
        .pclk(pclk), .presetn(presetn),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en),
        .reg_address_des(reg_address_des), .data_write_to_reg(data_write_to_reg),
        .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid), .reg_err(reg_err),
        .rx_data_in(rx_data_in), .tx_done_signal(tx_done_signal),
        .rx_done_signal(rx_done_signal), .parity_error_signal(parity_error_signal),
        .tx_data(tx_data), .start_tx(start_tx), .data_bit_num(data_bit_num),
        .stop_bit_num(stop_bit_num), .parity_en(parity_en), .parity_type(parity_type),
        .tx_done(tx_done), .rx_done(rx_done), .rx_data(rx_data), .parity_error(parity_error)
    );

    initial forever #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: register map as a byte array indexed by address/4, launch sequence as a phase.
    logic [7:0] m_reg [0:7];
    logic       m_rxst, m_parst, m_tdq, m_valid, m_err, m_start;
    logic [7:0] m_rdata;
    int         m_phase;   // 0 idle, 1 waiting for TX idle, 2 launching, 3 waiting for TX to start
    logic [2:0] a_idx;
    logic       a_al;
    assign a_idx = reg_address_des[4:2];
    assign a_al  = (reg_address_des[1:0] == 2'b00);

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < 8; i++) m_reg[i] <= 8'h00;
            m_reg[2] <= 8'h03;
            m_rxst <= 1'b0; m_parst <= 1'b0; m_tdq <= 1'b0;
            m_valid <= 1'b0; m_err <= 1'b0; m_start <= 1'b0;
            m_rdata <= 8'h00; m_phase <= 0;
        end else begin
            m_err <= 1'b0; m_valid <= 1'b0; m_start <= 1'b0;
            m_tdq <= tx_done;
            if (rx_done) m_reg[1] <= rx_data;
            if (reg_rd_en && !reg_wr_en && a_al && a_idx == 3'd4) begin
                m_rxst  <= rx_done;
                m_parst <= parity_error;
            end else begin
                if (rx_done)      m_rxst  <= 1'b1;
                if (parity_error) m_parst <= 1'b1;
            end
            if (reg_wr_en) begin
                if (reg_rd_en) m_err <= 1'b1;
                if (!a_al || a_idx == 3'd1 || a_idx >= 3'd4) m_err <= 1'b1;
                else if (a_idx == 3'd3) begin
                    if (data_write_to_reg[0]) begin
                        if (m_phase != 0) m_err <= 1'b1;
                        else begin m_reg[3] <= 8'h01; m_phase <= 1; end
                    end
                end else if (m_phase != 0) m_err <= 1'b1;
                else m_reg[a_idx] <= (a_idx == 3'd2) ? (data_write_to_reg & 8'h1F) : data_write_to_reg;
            end else if (reg_rd_en) begin
                m_valid <= 1'b1;
                if (!a_al || a_idx > 3'd4) begin m_rdata <= 8'h00; m_err <= 1'b1; end
                else if (a_idx == 3'd4) m_rdata <= {5'b00000, m_parst, m_rxst, m_tdq};
                else m_rdata <= m_reg[a_idx];
            end
            if (m_phase == 1 && tx_done) begin m_phase <= 2; m_start <= 1'b1; end
            if (m_phase == 2) begin m_phase <= 3; m_reg[3] <= 8'h00; end
            if (m_phase == 3 && !tx_done) m_phase <= 0;
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            check("rd_data",   32'(reg_rd_data),         32'(m_rdata));
            check("rd_valid",  32'(reg_rd_valid),        32'(m_valid));
            check("reg_err",   32'(reg_err),             32'(m_err));
            check("rx_data_in",32'(rx_data_in),          32'(m_reg[1]));
            check("tx_done_s", 32'(tx_done_signal),      32'(m_tdq));
            check("rx_done_s", 32'(rx_done_signal),      32'(m_rxst));
            check("par_err_s", 32'(parity_error_signal), 32'(m_parst));
            check("tx_data",   32'(tx_data),             32'(m_reg[0]));
            check("start_tx",  32'(start_tx),            32'(m_start));
            check("cfg_out",   32'({parity_type, parity_en, stop_bit_num, data_bit_num}), 32'(m_reg[2][4:0]));
        end
    end

    task automatic access(input logic wr, input logic rd, input logic [4:0] a, input logic [7:0] d);
        @(negedge pclk);
        reg_wr_en = wr; reg_rd_en = rd; reg_address_des = a; data_write_to_reg = d;
        @(negedge pclk);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [4:0] a, input logic [7:0] exp);
        access(1'b0, 1'b1, a, 8'h00);
        check(name, 32'(reg_rd_data), 32'(exp));
        check({name, "_vld"}, 32'(reg_rd_valid), 1);
    endtask

    initial begin
        int r;
        int k;
        logic [4:0] addrs [0:3];
        addrs[0] = 5'h00; addrs[1] = 5'h04; addrs[2] = 5'h0C; addrs[3] = 5'h10;

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_start_tx", 32'(start_tx), 0);
        check("rst_dbn", 32'(data_bit_num), 3);
        check("rst_err", 32'(reg_err), 0);
        presetn = 1'b1;
        chk_en  = 1'b1;
        read_expect("rst_cfg", 5'h08, 8'h03);
        for (int i = 0; i < 4; i++) read_expect("rst_rd", addrs[i], 8'h00);

        // Launch with TX idle
        tx_done = 1'b1;
        access(1'b1, 1'b0, 5'h00, 8'hA5);
        check("wr_tx_err", 32'(reg_err), 0);
        access(1'b1, 1'b0, 5'h0C, 8'h01);
        check("launch_pend", 32'(start_tx), 0);
        @(negedge pclk);
        check("launch_pulse", 32'(start_tx), 1);
        check("launch_txd", 32'(tx_data), 'hA5);
        tx_done = 1'b0;
        @(negedge pclk);
        check("launch_once", 32'(start_tx), 0);
        @(negedge pclk);
        read_expect("ctrl_after", 5'h0C, 8'h00);

        // Pending launch while TX busy
        access(1'b1, 1'b0, 5'h0C, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("pend_hold", 32'(start_tx), 0);
        end
        access(1'b1, 1'b0, 5'h00, 8'h3C);
        check("busy_wr_err", 32'(reg_err), 1);
        check("busy_txd", 32'(tx_data), 'hA5);
        read_expect("ctrl_pend", 5'h0C, 8'h01);
        tx_done = 1'b1;
        @(negedge pclk);
        check("pend_launch", 32'(start_tx), 1);
        tx_done = 1'b0;
        repeat (2) @(negedge pclk);
        tx_done = 1'b1;
        repeat (2) @(negedge pclk);

        // RX byte with parity error
        rx_data = 8'h5A; rx_done = 1'b1; parity_error = 1'b1;
        @(negedge pclk);
        rx_done = 1'b0; parity_error = 1'b0;
        check("rx_byte", 32'(rx_data_in), 'h5A);
        read_expect("stt_all", 5'h10, 8'h07);
        read_expect("stt_clr", 5'h10, 8'h01);

        // Clear and set in the same cycle
        @(negedge pclk);
        reg_rd_en = 1'b1; reg_address_des = 5'h10; rx_done = 1'b1; rx_data = 8'hC3;
        @(negedge pclk);
        reg_rd_en = 1'b0; rx_done = 1'b0;
        check("coll_rd", 32'(reg_rd_data), 'h01);
        check("coll_sticky", 32'(rx_done_signal), 1);
        read_expect("coll_stt", 5'h10, 8'h03);

        // Illegal accesses
        access(1'b1, 1'b0, 5'h10, 8'hFF);
        check("wr_stt_err", 32'(reg_err), 1);
        read_expect("wr_stt_nochg", 5'h10, 8'h01);
        access(1'b0, 1'b1, 5'h14, 8'h00);
        check("rd_unmap_err", 32'(reg_err), 1);
        check("rd_unmap_data", 32'(reg_rd_data), 0);
        access(1'b1, 1'b0, 5'h04, 8'hFF);
        check("wr_rx_err", 32'(reg_err), 1);
        read_expect("wr_rx_nochg", 5'h04, 8'hC3);
        read_expect("cfg_before", 5'h08, 8'h03);
        access(1'b1, 1'b1, 5'h00, 8'h77);
        check("wrrd_err", 32'(reg_err), 1);
        check("wrrd_novld", 32'(reg_rd_valid), 0);
        check("wrrd_hold", 32'(reg_rd_data), 'h03);
        check("wrrd_write", 32'(tx_data), 'h77);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge pclk);
            presetn = 1'b1;
            r = $urandom_range(0, 99);
            reg_wr_en = (r < 30);
            reg_rd_en = (r >= 25 && r < 60);
            k = $urandom_range(0, 8);
            if (k < 5)       reg_address_des = 5'(k * 4);
            else if (k == 5) reg_address_des = 5'h0C;
            else if (k == 6) reg_address_des = 5'h10;
            else             reg_address_des = 5'($urandom);
            data_write_to_reg = 8'($urandom);
            rx_done      = ($urandom_range(0, 11) == 0);
            parity_error = ($urandom_range(0, 19) == 0);
            rx_data      = 8'($urandom);
            if ($urandom_range(0, 5) == 0) tx_done = ~tx_done;
            if ($urandom_range(0, 499) == 0) begin
                #2 presetn = 1'b0;
            end
        end
        @(negedge pclk);
        reg_wr_en = 1'b0; reg_rd_en = 1'b0; rx_done = 1'b0; parity_error = 1'b0; presetn = 1'b1;
        repeat (3) @(negedge pclk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
